ras: RTL and testbench
======================

// Module: ras
// PURPOSE
//   Return address stack consumed by branch_predictor in the fetch stage. Call instructions push
//   their return address, returns pop, and a context-switch jalr does both in one cycle. The
//   current top-of-stack address is offered combinationally as the predicted return target.
//   Recursive calls to the same return site are compressed into a per-entry repeat counter.
// PARAMETERS
//   DEPTH          16  number of stack entries; must be a power of 2, at least 2
//   COUNTER_WIDTH  8   width of the per-entry repeat counter; saturates at 2^COUNTER_WIDTH-1
// PORTS
//   clk          in   1            clock; all state updates on the rising edge
//   rst          in   1            synchronous, active-high reset
//   bp_ras_addr  in   ADDR_WIDTH   return address to push (pc+4 of the call)
//   bp_ras_push  in   1            push request
//   bp_ras_pop   in   1            pop request; may be asserted together with push
//   ras_flush    in   1            pipeline flush; empties the stack
//   ras_bp_addr  out  ADDR_WIDTH   predicted return address = entry[top].addr, combinational
// BEHAVIOUR
//   State: entry[DEPTH] = {addr, cnt}; top (log2 DEPTH bits); used (0..DEPTH, log2 DEPTH+1 bits).
//   Reset (rst=1 at the clock edge): top=0, used=0, all addr=0, all cnt=0. ras_bp_addr=0 afterwards.
//   Read: ras_bp_addr is always entry[top].addr, with zero latency, including when used==0.
//     When used==0 it returns a stale or reset value. Fetch treats it as a prediction only.
//   Updates take effect at the next edge. Priority: rst > ras_flush > push/pop.
//   ras_flush: top=0, used=0, all cnt=0. Addr storage is left unchanged.
//   Push only:
//     - used!=0, entry[top].addr==bp_ras_addr and entry[top].cnt is not saturated: cnt++.
//     - otherwise: top=top+1 (mod DEPTH), entry[top]={bp_ras_addr,0}, used=min(used+1,DEPTH).
//     - overflow (used==DEPTH): the write silently overwrites the oldest entry.
//   Pop only:
//     - used==0: no state change (underflow ignored).
//     - entry[top].cnt>0: cnt--.
//     - otherwise: top=top-1 (mod DEPTH), used--.
//   Push and pop together (context switch):
//     - The read value this cycle is the old top.
//     - used==0: behaves as push only.
//     - entry[top].cnt==0: entry[top]={bp_ras_addr,0}; top and used unchanged.
//     - entry[top].cnt>0: entry[top].cnt--, then top=top+1, entry[top]={bp_ras_addr,0},
//       used=min(used+1,DEPTH).
//     - No compression merge is applied on this path.
//   Wrap-around: top arithmetic is modulo DEPTH. used saturates at DEPTH and never underflows.
//   Idle (neither push nor pop): state is held.
// STRUCTURE
//   Add ras_entry_t {addr[ADDR_WIDTH], cnt[COUNTER_WIDTH]} and RAS_DEPTH / RAS_COUNTER_WIDTH
//   defaults to common.svh / config.svh. ADDR_WIDTH comes from config.svh.
//   No sub-module: the storage is a flop array, and next-state is computed in one always_comb
//   (next_top, next_used, write enable and index) followed by one always_ff.
// TESTING
//   1. Reset, then read: ras_bp_addr==0. Pop with used==0: ras_bp_addr stays 0 and used stays 0.
//   2. Push 'h80100024, then push 'h80100100:
//      - ras_bp_addr=='h80100100.
//      - One pop -> 'h80100024; a second pop -> used==0.
//   3. Compression: push 'h80100024 three times -> one entry, cnt==2.
//      Three pops are needed before used==0; ras_bp_addr=='h80100024 throughout.
//   4. Push/pop together with top cnt==0 and top 'h80100024, bp_ras_addr='h80aabbc0:
//      - This cycle ras_bp_addr=='h80100024.
//      - Next cycle ras_bp_addr=='h80aabbc0 and used is unchanged.
//   5. Overflow at DEPTH=16: push 'h1000+4*i for i=0..16:
//      - used==16 and top holds 'h1040.
//      - 16 pops return 'h1040 down to 'h1004; the oldest entry 'h1000 is lost.
//   6. Push 'h80100024, then ras_flush=1 together with push 'h80100200:
//      - Next cycle used==0 (flush wins over the push).
//      - A subsequent push 'h80100300 gives ras_bp_addr=='h80100300.

Source files
------------

// File: rtl/ras_pkg.sv
// Shared types and defaults for the return address stack.
// Address width and stack geometry used by the fetch stage.
package ras_pkg;

    localparam int ADDR_WIDTH        = 32;
    localparam int RAS_DEPTH         = 16;
    localparam int RAS_COUNTER_WIDTH = 8;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]        addr;
        logic [RAS_COUNTER_WIDTH-1:0] cnt;
    } ras_entry_t;

endpackage

// File: rtl/ras.sv
// Return address stack with per-entry repeat compression.
// Top-of-stack address is offered combinationally as the prediction.
module ras
    import ras_pkg::*;
#(
    parameter int DEPTH         = RAS_DEPTH,
    parameter int COUNTER_WIDTH = RAS_COUNTER_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] bp_ras_addr,
    input  logic                  bp_ras_push,
    input  logic                  bp_ras_pop,
    input  logic                  ras_flush,
    output logic [ADDR_WIDTH-1:0] ras_bp_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam int UW = PW + 1;
    localparam logic [UW-1:0] FULL = UW'(DEPTH);

    logic [ADDR_WIDTH-1:0]    addr_q [DEPTH];
    logic [COUNTER_WIDTH-1:0] cnt_q  [DEPTH];
    logic [PW-1:0]            top_q;
    logic [UW-1:0]            used_q;

    logic [PW-1:0]            next_top;
    logic [UW-1:0]            next_used;
    logic                     wr_en;
    logic [PW-1:0]            wr_idx;
    logic                     cnt_inc;
    logic                     cnt_dec;

    logic [COUNTER_WIDTH-1:0] top_cnt;
    logic [PW-1:0]            top_inc;
    logic [UW-1:0]            used_inc;
    logic                     empty;
    logic                     push_only;
    logic                     swap;
    logic                     pop_only;

    assign ras_bp_addr = addr_q[top_q];
    assign top_cnt     = cnt_q[top_q];
    assign top_inc     = top_q + PW'(1);
    assign empty       = (used_q == '0);
    assign used_inc    = (used_q == FULL) ? used_q : used_q + UW'(1);

    // A push/pop pair on an empty stack degrades to a plain push.
    assign push_only = bp_ras_push && (!bp_ras_pop || empty);
    assign swap      = bp_ras_push && bp_ras_pop && !empty;
    assign pop_only  = bp_ras_pop && !bp_ras_push && !empty;

    // Next-state: pointer moves, entry write and top-counter adjust.
    always_comb begin
        next_top  = top_q;
        next_used = used_q;
        wr_en     = 1'b0;
        wr_idx    = top_q;
        cnt_inc   = 1'b0;
        cnt_dec   = 1'b0;
        unique case (1'b1)
            push_only: begin
                if (!empty && addr_q[top_q] == bp_ras_addr
                        && !(&top_cnt)) begin
                    cnt_inc = 1'b1;
                end else begin
                    next_top  = top_inc;
                    next_used = used_inc;
                    wr_en     = 1'b1;
                    wr_idx    = top_inc;
                end
            end
            swap: begin
                wr_en = 1'b1;
                if (top_cnt != '0) begin
                    cnt_dec   = 1'b1;
                    next_top  = top_inc;
                    next_used = used_inc;
                    wr_idx    = top_inc;
                end
            end
            pop_only: begin
                if (top_cnt != '0) begin
                    cnt_dec = 1'b1;
                end else begin
                    next_top  = top_q - PW'(1);
                    next_used = used_q - UW'(1);
                end
            end
            default: ;
        endcase
    end

    // State update; flush clears counters but keeps stale addresses.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_q  <= '0;
            used_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else if (ras_flush) begin
            top_q  <= '0;
            used_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            top_q  <= next_top;
            used_q <= next_used;
            if (cnt_inc) cnt_q[top_q] <= top_cnt + COUNTER_WIDTH'(1);
            if (cnt_dec) cnt_q[top_q] <= top_cnt - COUNTER_WIDTH'(1);
            if (wr_en) begin
                addr_q[wr_idx] <= bp_ras_addr;
                cnt_q[wr_idx]  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ras.sv
// Directed bench for the return address stack.
// Each task drives one scenario and checks against hand-computed values.
module tb_ras;
    import ras_pkg::*;

    logic                  clk;
    logic                  rst;
    logic [ADDR_WIDTH-1:0] bp_ras_addr;
    logic                  bp_ras_push;
    logic                  bp_ras_pop;
    logic                  ras_flush;
    logic [ADDR_WIDTH-1:0] ras_bp_addr;

    int checks;
    int errors;

    ras dut (
        .clk         (clk),
        .rst         (rst),
        .bp_ras_addr (bp_ras_addr),
        .bp_ras_push (bp_ras_push),
        .bp_ras_pop  (bp_ras_pop),
        .ras_flush   (ras_flush),
        .ras_bp_addr (ras_bp_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, limit 200000 reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        bp_ras_push = 1'b0;
        bp_ras_pop  = 1'b0;
        ras_flush   = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
    endtask

    task automatic push(input logic [ADDR_WIDTH-1:0] a);
        bp_ras_addr = a;
        bp_ras_push = 1'b1;
        step();
    endtask

    task automatic pop();
        bp_ras_pop = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ras_bp_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr got %h want 0", ras_bp_addr);
        end
        checks++;
        if (dut.used_q !== 5'd0) begin
            errors++;
            $display("FAIL reset_used got %0d want 0", dut.used_q);
        end
        pop();
        checks++;
        if (ras_bp_addr !== 32'h0) begin
            errors++;
            $display("FAIL underflow_addr got %h want 0", ras_bp_addr);
        end
        checks++;
        if (dut.used_q !== 5'd0) begin
            errors++;
            $display("FAIL underflow_used got %0d want 0", dut.used_q);
        end
    endtask

    task automatic test_push_pop();
        push(32'h80100024);
        push(32'h80100100);
        checks++;
        if (ras_bp_addr !== 32'h80100100) begin
            errors++;
            $display("FAIL pp_top got %h want 80100100", ras_bp_addr);
        end
        pop();
        checks++;
        if (ras_bp_addr !== 32'h80100024) begin
            errors++;
            $display("FAIL pp_pop1 got %h want 80100024", ras_bp_addr);
        end
        pop();
        checks++;
        if (dut.used_q !== 5'd0) begin
            errors++;
            $display("FAIL pp_used got %0d want 0", dut.used_q);
        end
    endtask

    task automatic test_compress();
        logic [7:0] c;
        do_reset();
        repeat (3) push(32'h80100024);
        c = dut.cnt_q[dut.top_q];
        checks++;
        if (dut.used_q !== 5'd1 || c !== 8'd2) begin
            errors++;
            $display("FAIL cmp_fill used %0d cnt %0d want 1 2",
                     dut.used_q, c);
        end
        for (int k = 0; k < 2; k++) begin
            pop();
            checks++;
            if (ras_bp_addr !== 32'h80100024 || dut.used_q !== 5'd1) begin
                errors++;
                $display("FAIL cmp_pop%0d addr %h used %0d want 80100024 1",
                         k, ras_bp_addr, dut.used_q);
            end
        end
        pop();
        checks++;
        if (dut.used_q !== 5'd0) begin
            errors++;
            $display("FAIL cmp_empty got %0d want 0", dut.used_q);
        end
    endtask

    task automatic test_swap();
        do_reset();
        push(32'h80100024);
        bp_ras_addr = 32'h80aabbc0;
        bp_ras_push = 1'b1;
        bp_ras_pop  = 1'b1;
        #1;
        checks++;
        if (ras_bp_addr !== 32'h80100024) begin
            errors++;
            $display("FAIL swap_old got %h want 80100024", ras_bp_addr);
        end
        step();
        checks++;
        if (ras_bp_addr !== 32'h80aabbc0 || dut.used_q !== 5'd1) begin
            errors++;
            $display("FAIL swap_new addr %h used %0d want 80aabbc0 1",
                     ras_bp_addr, dut.used_q);
        end
        push(32'h80aabbc0);
        push(32'h80100200);
        pop();
        bp_ras_addr = 32'h80300000;
        bp_ras_push = 1'b1;
        bp_ras_pop  = 1'b1;
        step();
        checks++;
        if (ras_bp_addr !== 32'h80300000 || dut.used_q !== 5'd2) begin
            errors++;
            $display("FAIL swap_cnt addr %h used %0d want 80300000 2",
                     ras_bp_addr, dut.used_q);
        end
        pop();
        checks++;
        if (ras_bp_addr !== 32'h80aabbc0 || dut.used_q !== 5'd1) begin
            errors++;
            $display("FAIL swap_back addr %h used %0d want 80aabbc0 1",
                     ras_bp_addr, dut.used_q);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp;
        do_reset();
        for (int i = 0; i <= 16; i++) push(32'h1000 + 32'(4 * i));
        checks++;
        if (dut.used_q !== 5'd16 || ras_bp_addr !== 32'h1040) begin
            errors++;
            $display("FAIL ovf_full used %0d addr %h want 16 1040",
                     dut.used_q, ras_bp_addr);
        end
        for (int k = 0; k < 16; k++) begin
            exp = 32'h1040 - 32'(4 * k);
            checks++;
            if (ras_bp_addr !== exp) begin
                errors++;
                $display("FAIL ovf_pop%0d got %h want %h", k, ras_bp_addr, exp);
            end
            pop();
        end
        checks++;
        if (dut.used_q !== 5'd0) begin
            errors++;
            $display("FAIL ovf_empty got %0d want 0", dut.used_q);
        end
    endtask

    task automatic test_flush();
        do_reset();
        push(32'h80100024);
        bp_ras_addr = 32'h80100200;
        bp_ras_push = 1'b1;
        ras_flush   = 1'b1;
        step();
        checks++;
        if (dut.used_q !== 5'd0) begin
            errors++;
            $display("FAIL flush_used got %0d want 0", dut.used_q);
        end
        push(32'h80100300);
        checks++;
        if (ras_bp_addr !== 32'h80100300 || dut.used_q !== 5'd1) begin
            errors++;
            $display("FAIL flush_push addr %h used %0d want 80100300 1",
                     ras_bp_addr, dut.used_q);
        end
    endtask

    task automatic test_saturate();
        logic [7:0] c;
        logic [3:0] below;
        do_reset();
        repeat (257) push(32'h80200000);
        c = dut.cnt_q[dut.top_q];
        below = dut.top_q - 4'd1;
        checks++;
        if (dut.used_q !== 5'd2 || c !== 8'd0) begin
            errors++;
            $display("FAIL sat_split used %0d cnt %0d want 2 0",
                     dut.used_q, c);
        end
        checks++;
        if (dut.cnt_q[below] !== 8'd255) begin
            errors++;
            $display("FAIL sat_cnt got %0d want 255", dut.cnt_q[below]);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        bp_ras_addr = '0;
        bp_ras_push = 1'b0;
        bp_ras_pop  = 1'b0;
        ras_flush   = 1'b0;
        @(negedge clk);
        test_reset();
        test_push_pop();
        test_compress();
        test_swap();
        test_overflow();
        test_flush();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
